// File: rtl/mmio_arbiter.sv
// Round-robin arbiter sharing one mmio_controller bus among REQUESTERS one-word requesters.
// Optional bus locking is compiled in with MMIO_ARB_LOCK_EN (adds the req_lock input).
module mmio_arbiter #(
  parameter int REQUESTERS = 2,
  parameter int WIDTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [REQUESTERS-1:0]       req_valid,
  input  logic [REQUESTERS-1:0]       req_write,
  input  logic [REQUESTERS*WIDTH-1:0] req_addr,
  input  logic [REQUESTERS*WIDTH-1:0] req_wdata,
`ifdef MMIO_ARB_LOCK_EN
  input  logic [REQUESTERS-1:0]       req_lock,
`endif
  output logic [REQUESTERS-1:0]       req_ready,
  output logic [REQUESTERS-1:0]       rsp_valid,
  output logic [WIDTH-1:0]            rsp_rdata,
  output logic [WIDTH-1:0]            addr,
  output logic [WIDTH-1:0]            d_in,
  output logic                        read,
  output logic                        write,
  input  logic [WIDTH-1:0]            d_out
);

  localparam int            PW   = $clog2(REQUESTERS);
  localparam logic [PW:0]   NREQ = (PW+1)'(REQUESTERS);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [PW-1:0]           r_rr_ptr;
  logic [PW-1:0]           r_win;
  logic [WIDTH-1:0]        r_addr;
  logic [WIDTH-1:0]        r_wdata;
  logic [WIDTH-1:0]        r_rdata;
  logic                    r_read;
  logic                    r_write;
  logic [REQUESTERS-1:0]   r_rsp_valid;
  logic [REQUESTERS-1:0]   w_valid_eff;
  logic                    w_found;
  logic [PW-1:0]           w_winner;
  logic                    w_accept;
  logic                    w_hold_ptr;

  function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] p);
    logic [PW:0] v;
    v = {1'b0, p} + {{PW{1'b0}}, 1'b1};
    if (v >= NREQ) begin
      v = '0;
    end else begin
      v = v;
    end
    return v[PW-1:0];
  endfunction

  function automatic logic [REQUESTERS-1:0] f_onehot(input logic [PW-1:0] idx);
    logic [REQUESTERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

`ifdef MMIO_ARB_LOCK_EN
  logic          r_lock_vld;
  logic [PW-1:0] r_lock_own;
  logic          r_win_lock;
  logic          w_release_idle;

  // While a lock owner exists only its request is visible to the scan
  always_comb begin
    if (r_lock_vld) begin
      w_valid_eff = req_valid & f_onehot(r_lock_own);
    end else begin
      w_valid_eff = req_valid;
    end
  end

  assign w_release_idle = (r_state == S_IDLE) && r_lock_vld && !req_valid[r_lock_own];
  assign w_hold_ptr     = r_win_lock;

  // Lock ownership: taken on a locked acceptance, dropped on an unlocked one or an idle owner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lock_vld <= 1'b0;
      r_lock_own <= '0;
      r_win_lock <= 1'b0;
    end else if (w_accept) begin
      r_win_lock <= req_lock[w_winner];
      r_lock_vld <= req_lock[w_winner];
      r_lock_own <= w_winner;
    end else if (w_release_idle) begin
      r_lock_vld <= 1'b0;
    end else begin
      r_lock_vld <= r_lock_vld;
    end
  end
`else
  assign w_valid_eff = req_valid;
  assign w_hold_ptr  = 1'b0;
`endif

  // Winner scan: first pending request at or above rr_ptr, wrapping modulo REQUESTERS
  always_comb begin
    logic [PW:0] v_idx;
    w_found  = 1'b0;
    w_winner = '0;
    v_idx    = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      v_idx = {1'b0, r_rr_ptr} + (PW+1)'(i);
      if (v_idx >= NREQ) begin
        v_idx = v_idx - NREQ;
      end else begin
        v_idx = v_idx;
      end
      if (!w_found && w_valid_eff[v_idx[PW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = v_idx[PW-1:0];
      end else begin
        w_found  = w_found;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:   w_state_nxt = w_found ? S_ACCESS : S_IDLE;
      S_ACCESS: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: acceptance and the same-cycle ready pulse
  always_comb begin
    w_accept  = 1'b0;
    req_ready = '0;
    case (r_state)
      S_IDLE: begin
        w_accept  = w_found;
        req_ready = w_found ? f_onehot(w_winner) : '0;
      end
      S_ACCESS: begin
        w_accept  = 1'b0;
        req_ready = '0;
      end
      default: begin
        w_accept  = 1'b0;
        req_ready = '0;
      end
    endcase
  end

  // Request capture, bus strobes and response generation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_rsp_valid <= '0;
    end else begin
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_rsp_valid <= '0;
      if (w_accept) begin
        r_win   <= w_winner;
        r_addr  <= req_addr[int'(w_winner)*WIDTH +: WIDTH];
        r_wdata <= req_wdata[int'(w_winner)*WIDTH +: WIDTH];
        r_read  <= !req_write[w_winner];
        r_write <= req_write[w_winner];
      end else begin
        r_win   <= r_win;
      end
      if (r_state == S_ACCESS) begin
        r_rsp_valid <= f_onehot(r_win);
        if (r_read) begin
          r_rdata <= d_out;
        end else begin
          r_rdata <= r_rdata;
        end
      end else begin
        r_rdata <= r_rdata;
      end
    end
  end

  // Round-robin pointer: advances past the winner unless the access was locked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if ((r_state == S_ACCESS) && !w_hold_ptr) begin
      r_rr_ptr <= f_next_ptr(r_win);
`ifdef MMIO_ARB_LOCK_EN
    end else if (w_release_idle) begin
      r_rr_ptr <= f_next_ptr(r_lock_own);
`endif
    end else begin
      r_rr_ptr <= r_rr_ptr;
    end
  end

  assign addr      = r_addr;
  assign d_in      = r_wdata;
  assign read      = r_read;
  assign write     = r_write;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Self-checking bench for mmio_arbiter (2 requesters, 16-bit); expected accesses are
// queued when requests are driven and popped when the bus strobe appears.
module tb_mmio_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [15:0] rsp_rdata;
  logic [15:0] addr;
  logic [15:0] d_in;
  logic        read;
  logic        write;
  logic [15:0] d_out;
`ifdef MMIO_ARB_LOCK_EN
  logic [1:0]  req_lock;
`endif

  typedef struct {
    int          req;
    logic        wr;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] r;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Peripheral model: fixed value at 0x0004, address-derived data elsewhere
  assign d_out = (addr == 16'h0004) ? 16'h1234 : (addr ^ 16'hA5A5);

  mmio_arbiter #(.REQUESTERS(2), .WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef MMIO_ARB_LOCK_EN
    .req_lock  (req_lock),
`endif
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .addr      (addr),
    .d_in      (d_in),
    .read      (read),
    .write     (write),
    .d_out     (d_out)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic wr,
                         input logic [15:0] a, input logic [15:0] d);
    req_valid[i]          = v;
    req_write[i]          = wr;
    req_addr[i*16 +: 16]  = a;
    req_wdata[i*16 +: 16] = d;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    req_valid = 2'b00;
    req_write = 2'b00;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
`ifdef MMIO_ARB_LOCK_EN
    req_lock  = 2'b00;
`endif
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({req_ready, rsp_valid} !== 4'b0000) begin
      failures++; $display("FAIL reset_pulses: got %b expected 0000", {req_ready, rsp_valid});
    end
    checks++;
    if ({read, write} !== 2'b00) begin
      failures++; $display("FAIL reset_strobes: got %b expected 00", {read, write});
    end
    checks++;
    if ({addr, d_in, rsp_rdata} !== 48'h0) begin
      failures++; $display("FAIL reset_data: got %h expected 0", {addr, d_in, rsp_rdata});
    end
    tick;
    rst = 1'b0;
  endtask

  task automatic test_single_write;
    exp_t e;
    set_req(0, 1'b1, 1'b1, 16'h0000, 16'hBEEF);
    q.push_back(exp_t'{req: 0, wr: 1'b1, a: 16'h0000, d: 16'hBEEF, r: 16'h0000});
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++; $display("FAIL wr_ready: got %b expected 01", req_ready);
    end
    tick;
    req_valid[0] = 1'b0;
    #1;
    e = q.pop_front();
    checks++;
    if ({write, read} !== {e.wr, !e.wr} || addr !== e.a || d_in !== e.d) begin
      failures++; $display("FAIL wr_bus: got w=%b r=%b a=%h d=%h expected w=1 r=0 a=%h d=%h",
                           write, read, addr, d_in, e.a, e.d);
    end
    tick;
    #1;
    checks++;
    if (rsp_valid !== 2'b01 || read !== 1'b0 || write !== 1'b0) begin
      failures++; $display("FAIL wr_rsp: got rsp=%b r=%b w=%b expected rsp=01 r=0 w=0", rsp_valid, read, write);
    end
    tick;
    #1;
    checks++;
    if (rsp_valid !== 2'b00 || read !== 1'b0) begin
      failures++; $display("FAIL wr_rsp_end: got rsp=%b r=%b expected 00 0", rsp_valid, read);
    end
  endtask

  task automatic test_single_read;
    exp_t e;
    tick;
    set_req(1, 1'b1, 1'b0, 16'h0004, 16'h0000);
    q.push_back(exp_t'{req: 1, wr: 1'b0, a: 16'h0004, d: 16'h0000, r: 16'h1234});
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      failures++; $display("FAIL rd_ready: got %b expected 10", req_ready);
    end
    tick;
    req_valid[1] = 1'b0;
    #1;
    e = q.pop_front();
    checks++;
    if (read !== 1'b1 || write !== 1'b0 || addr !== e.a) begin
      failures++; $display("FAIL rd_bus: got r=%b w=%b a=%h expected r=1 w=0 a=%h", read, write, addr, e.a);
    end
    tick;
    #1;
    checks++;
    if (rsp_valid !== 2'b10 || rsp_rdata !== e.r || read !== 1'b0) begin
      failures++; $display("FAIL rd_rsp: got rsp=%b data=%h r=%b expected rsp=10 data=%h r=0",
                           rsp_valid, rsp_rdata, read, e.r);
    end
  endtask

  task automatic test_contention;
    exp_t       cur;
    logic [1:0] e_rdy;
    bit         have;
    have = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      q.push_back(exp_t'{req: 0, wr: 1'b0, a: 16'h0010, d: 16'h0000, r: 16'h0010 ^ 16'hA5A5});
      q.push_back(exp_t'{req: 1, wr: 1'b0, a: 16'h0020, d: 16'h0000, r: 16'h0020 ^ 16'hA5A5});
    end
    set_req(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    set_req(1, 1'b1, 1'b0, 16'h0020, 16'h0000);
    for (int c = 0; c < 8; c++) begin
      #1;
      if (c % 2 == 0) begin
        e_rdy = 2'b01 << q[0].req;
        checks++;
        if (req_ready !== e_rdy || read !== 1'b0) begin
          failures++; $display("FAIL cont_grant c=%0d: got rdy=%b r=%b expected rdy=%b r=0", c, req_ready, read, e_rdy);
        end
        if (have) begin
          checks++;
          if (rsp_valid !== (2'b01 << cur.req) || rsp_rdata !== cur.r) begin
            failures++; $display("FAIL cont_rsp c=%0d: got rsp=%b data=%h expected req %0d data=%h",
                                 c, rsp_valid, rsp_rdata, cur.req, cur.r);
          end
        end
      end else begin
        cur  = q.pop_front();
        have = 1'b1;
        checks++;
        if (read !== 1'b1 || write !== 1'b0 || addr !== cur.a || req_ready !== 2'b00) begin
          failures++; $display("FAIL cont_bus c=%0d: got r=%b w=%b a=%h rdy=%b expected r=1 w=0 a=%h rdy=00",
                               c, read, write, addr, req_ready, cur.a);
        end
      end
      tick;
    end
    req_valid = 2'b00;
    #1;
    checks++;
    if (rsp_valid !== (2'b01 << cur.req) || rsp_rdata !== cur.r || req_ready !== 2'b00) begin
      failures++; $display("FAIL cont_last: got rsp=%b data=%h rdy=%b expected req %0d data=%h rdy=00",
                           rsp_valid, rsp_rdata, req_ready, cur.req, cur.r);
    end
  endtask

  task automatic test_withdrawal;
    exp_t e;
    tick;
    set_req(0, 1'b1, 1'b1, 16'h0030, 16'h1111);
    q.push_back(exp_t'{req: 0, wr: 1'b1, a: 16'h0030, d: 16'h1111, r: 16'h0000});
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++; $display("FAIL wd_ready: got %b expected 01", req_ready);
    end
    tick;
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 1'b0, 16'h0040, 16'h0000);
    #1;
    e = q.pop_front();
    checks++;
    if (write !== 1'b1 || read !== 1'b0 || addr !== e.a || d_in !== e.d || req_ready !== 2'b00) begin
      failures++; $display("FAIL wd_bus: got w=%b r=%b a=%h d=%h rdy=%b expected w=1 r=0 a=%h d=%h rdy=00",
                           write, read, addr, d_in, req_ready, e.a, e.d);
    end
    tick;
    req_valid[1] = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 2'b01 || req_ready !== 2'b00) begin
      failures++; $display("FAIL wd_rsp: got rsp=%b rdy=%b expected 01 00", rsp_valid, req_ready);
    end
    for (int c = 0; c < 2; c++) begin
      tick;
      #1;
      checks++;
      if ({read, write} !== 2'b00 || req_ready !== 2'b00 || rsp_valid !== 2'b00 || addr !== e.a) begin
        failures++; $display("FAIL wd_quiet c=%0d: got rw=%b rdy=%b rsp=%b a=%h expected 00 00 00 a=%h",
                             c, {read, write}, req_ready, rsp_valid, addr, e.a);
      end
    end
  endtask

  task automatic test_reset_mid_access;
    tick;
    set_req(0, 1'b1, 1'b1, 16'h0001, 16'h2222);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++; $display("FAIL rma_ready: got %b expected 01", req_ready);
    end
    tick;
    req_valid[0] = 1'b0;
    #1;
    checks++;
    if (write !== 1'b1 || addr !== 16'h0001) begin
      failures++; $display("FAIL rma_bus: got w=%b a=%h expected w=1 a=0001", write, addr);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({read, write} !== 2'b00 || addr !== 16'h0000) begin
      failures++; $display("FAIL rma_async: got rw=%b a=%h expected 00 0000", {read, write}, addr);
    end
    tick;
    #1;
    checks++;
    if (rsp_valid !== 2'b00) begin
      failures++; $display("FAIL rma_norsp: got %b expected 00", rsp_valid);
    end
    tick;
    rst = 1'b0;
    set_req(0, 1'b1, 1'b0, 16'h0002, 16'h0000);
    set_req(1, 1'b1, 1'b0, 16'h0003, 16'h0000);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++; $display("FAIL rma_ptr: got %b expected 01", req_ready);
    end
    tick;
    req_valid = 2'b00;
    tick;
    #1;
    checks++;
    if (rsp_valid !== 2'b01 || rsp_rdata !== (16'h0002 ^ 16'hA5A5)) begin
      failures++; $display("FAIL rma_rsp: got rsp=%b data=%h expected 01 %h", rsp_valid, rsp_rdata, 16'h0002 ^ 16'hA5A5);
    end
  endtask

`ifdef MMIO_ARB_LOCK_EN
  task automatic test_lock;
    int         seq [5];
    logic [1:0] e_rdy;
    seq = '{0, 0, 0, 0, 1};
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    set_req(0, 1'b1, 1'b1, 16'h0050, 16'h5555);
    set_req(1, 1'b1, 1'b0, 16'h0060, 16'h0000);
    req_lock = 2'b01;
    for (int g = 0; g < 5; g++) begin
      #1;
      e_rdy = 2'b01 << seq[g];
      checks++;
      if (req_ready !== e_rdy) begin
        failures++; $display("FAIL lock_grant g=%0d: got %b expected %b", g, req_ready, e_rdy);
      end
      tick;
      if (g == 2) req_lock = 2'b00;
      if (g == 3) req_valid[0] = 1'b0;
      if (g == 4) req_valid[1] = 1'b0;
      tick;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single_write;
    test_single_read;
    test_contention;
    test_withdrawal;
    test_reset_mid_access;
`ifdef MMIO_ARB_LOCK_EN
    test_lock;
`endif
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_arbiter.md
# mmio_arbiter

Round-robin arbiter that shares the single MMIO bus of `mmio_controller` between up to four requesters, such as the CPU load/store path and a DMA engine. Each requester presents a one-word read or write request. The arbiter grants one request at a time, drives the controller's `addr`/`d_in`/`read`/`write` strobes for exactly one cycle, captures `d_out`, and returns a response pulse to the winning requester.

## Interface
Parameters:
- `REQUESTERS`, default 2: number of requesters, legal range 2..4.
- `WIDTH`, default 16: address and data width.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  REQUESTERS  request pending, one bit per requester.
- `req_write`  in  REQUESTERS  1 = write, 0 = read.
- `req_addr`  in  REQUESTERS*WIDTH  packed addresses; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_wdata`  in  REQUESTERS*WIDTH  packed write data, same packing as `req_addr`.
- `req_ready`  out  REQUESTERS  one-cycle acceptance pulse to the winner.
- `rsp_valid`  out  REQUESTERS  one-cycle completion pulse to the winner.
- `rsp_rdata`  out  WIDTH  read data shared by all requesters; meaningful only while `rsp_valid` is high for a read.
- `addr`  out  WIDTH  to `mmio_controller`.
- `d_in`  out  WIDTH  to `mmio_controller`.
- `read`  out  1  to `mmio_controller`.
- `write`  out  1  to `mmio_controller`.
- `d_out`  in  WIDTH  from `mmio_controller`; combinational, valid in the same cycle as `read`.

## Operation
- The FSM has two states, IDLE and ACCESS. The reset state is IDLE.
- IDLE with no `req_valid` bits set: the FSM stays in IDLE.
- IDLE with at least one `req_valid` bit set:
  - The winner is the first set bit found when scanning upward from `rr_ptr`, wrapping modulo REQUESTERS.
  - The arbiter registers the winner's addr, wdata and write flag, and records the winner index.
  - `req_ready[winner]` pulses for this one cycle.
  - The FSM moves to ACCESS.
- ACCESS:
  - `addr` and `d_in` come from the registered request.
  - Exactly one of `read`/`write` is high, for this single cycle.
  - For a read, `d_out` is captured into `rsp_rdata` at the end of the cycle.
  - `rr_ptr` becomes (winner+1) mod REQUESTERS.
  - The FSM returns to IDLE.
- The cycle after ACCESS: `rsp_valid[winner]` is high for one cycle. On a write, `rsp_rdata` holds its previous value.
- Requesters must hold `req_valid`, `req_addr`, `req_wdata` and `req_write` stable until they see `req_ready`. Dropping `req_valid` before `req_ready` withdraws the request with no side effect.
- Idle bus values: `read`=`write`=0, and `addr`/`d_in` hold their last driven values.
- Address and data are forwarded unmodified; there is no decoding or range checking.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `addr`=0, `d_in`=0, `read`=0, `write`=0, `rr_ptr`=0, FSM=IDLE.
- Latency: a request first sampled in IDLE at cycle N gets `req_ready` in cycle N, bus strobe in cycle N+1, and `rsp_valid` in cycle N+2.
- Throughput: one access every 2 cycles. The arbiter may accept a new request in the same cycle that `rsp_valid` of the previous one is high.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep `req_valid` asserted and are served in round-robin order.
- A single persistent requester is granted every other cycle; no idle cycle is inserted.
- Reset asserted mid-ACCESS:
  - Strobes drop immediately, without waiting for a clock edge.
  - The in-flight access is discarded and no `rsp_valid` is produced.
- `rr_ptr` wraps from REQUESTERS-1 to 0.

## Configuration
- `MMIO_ARB_LOCK_EN` defined:
  - Adds input `req_lock` (REQUESTERS bits), sampled at acceptance.
  - If the accepted request has its lock bit set, `rr_ptr` is not advanced and the winner becomes lock owner.
  - While a lock owner exists, only the owner can win in IDLE. Other requesters are not granted until the lock is released.
  - The lock is released when the owner has an access accepted with its lock bit low, or when the owner's `req_valid` is low in an IDLE cycle. On release, `rr_ptr` advances past the owner.
  - Reset clears the lock.
- Not defined: the `req_lock` port is absent and arbitration is pure round-robin.

## Test plan
- Reset then single write: requester 0 writes addr=0x0000, wdata=0xBEEF -> `req_ready[0]` in cycle 0, `write`=1 with `addr`=0, `d_in`=0xBEEF in cycle 1, `rsp_valid[0]` in cycle 2, `read` never asserted.
- Single read: requester 1 reads addr=0x0004 with the model `d_out`=0x1234 during the strobe -> `read`=1 for exactly one cycle, then `rsp_valid[1]`=1 with `rsp_rdata`=0x1234.
- Contention: both requesters hold reads from reset -> grants alternate 0,1,0,1 and bus strobes occur every 2 cycles.
- Withdrawal: requester 1 raises then drops `req_valid` while requester 0 is in ACCESS -> no `req_ready[1]`, no bus activity for requester 1.
- Reset mid-access: assert `rst` during the ACCESS cycle of a write to addr 0x0001 -> `write` falls without a clock edge, no `rsp_valid`, `rr_ptr`=0 afterwards.
- With `MMIO_ARB_LOCK_EN`: requester 0 issues 3 locked writes while requester 1 requests continuously -> requester 0 granted 3 times consecutively. Its 4th request has lock low and is also granted, then requester 1 is granted next.
